// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Response-tracking entries record which requester owns each outstanding transaction.
package mem_arb_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        req_id_t id;
        logic    drop;
    } rsp_entry_t;

    // An instruction entry touched by a flush must not forward its response.
    function automatic rsp_entry_t apply_flush(rsp_entry_t e, logic flush);
        rsp_entry_t r;
        r = e;
        if (flush && (e.id == REQ_INSTR)) begin
            r.drop = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_id_fifo.sv
// In-order FIFO of outstanding transaction owners, with a bulk "drop all instr entries"
// input used by fetch flush. The head view already reflects a same-cycle flush.
module rsp_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  rsp_entry_t                   push_entry,
    input  logic                         pop,
    input  logic                         flush_instr,
    output rsp_entry_t                   head,
    output logic [$clog2(DEPTH + 1)-1:0] count,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rsp_entry_t       entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PTR_W'(i)] <= '{id: REQ_INSTR, drop: 1'b0};
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PTR_W'(i)] <= apply_flush(entries_q[PTR_W'(i)], flush_instr);
            end
            // A push overrides the flush update of its own slot; the caller pre-flushes it.
            if (push) begin
                entries_q[wr_ptr_q] <= push_entry;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        head  = apply_flush(entries_q[rd_ptr_q], flush_instr);
        count = count_q;
        empty = (count_q == '0);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one req/gnt/rvalid memory port between instruction fetch and load/store,
// locking an ungranted address phase and routing in-order responses back to their owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_req_in,
    input  logic [ADDR_W-1:0]   instr_addr_in,
    input  logic                instr_flush_in,
    output logic                instr_gnt_out,
    output logic                instr_rvalid_out,
    output logic [DATA_W-1:0]   instr_rdata_out,
    input  logic                data_req_in,
    input  logic [ADDR_W-1:0]   data_addr_in,
    input  logic                data_we_in,
    input  logic [DATA_W/8-1:0] data_be_in,
    input  logic [DATA_W-1:0]   data_wdata_in,
    output logic                data_gnt_out,
    output logic                data_rvalid_out,
    output logic [DATA_W-1:0]   data_rdata_out,
    output logic                mem_req_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic                mem_we_out,
    output logic [DATA_W/8-1:0] mem_be_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    input  logic                mem_gnt_in,
    input  logic                mem_rvalid_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                err_unexpected_rsp_out
);

    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          state_q;
    req_id_t             owner_q;
    logic [STARVE_W-1:0] starve_q;
    logic                drop_pend_q;
    logic                err_q;

    req_id_t    winner;
    req_id_t    owner;
    logic       instr_forced;
    logic       owner_req;
    logic       req_ok;
    logic       gnt_fire;
    logic       push;
    logic       pop;
    rsp_entry_t push_entry;
    rsp_entry_t head;
    logic [CNT_W-1:0] count;
    logic       empty;

    always_comb begin
        instr_forced = (starve_q == STARVE_W'(STARVE_LIMIT));
        winner       = (instr_req_in && (instr_forced || !data_req_in)) ? REQ_INSTR : REQ_DATA;
        owner        = (state_q == LOCKED) ? owner_q : winner;
        owner_req    = (owner == REQ_DATA) ? data_req_in : instr_req_in;
        // Occupancy is the registered count: a same-cycle pop does not free a slot.
        req_ok       = owner_req && ((state_q == LOCKED) || (count < CNT_W'(MAX_OUTSTANDING)));
        gnt_fire     = req_ok && mem_gnt_in;
        push         = gnt_fire;
        pop          = mem_rvalid_in && !empty;
        push_entry.id   = owner;
        push_entry.drop = (owner == REQ_INSTR) && (instr_flush_in || drop_pend_q);
    end

    rsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_id_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .flush_instr (instr_flush_in),
        .head        (head),
        .count       (count),
        .empty       (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= REQ_INSTR;
            starve_q    <= '0;
            drop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_ok && !mem_gnt_in) begin
                        state_q <= LOCKED;
                        owner_q <= winner;
                    end
                end
                LOCKED: begin
                    if (gnt_fire) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (!instr_req_in || (gnt_fire && (owner == REQ_INSTR))) begin
                starve_q <= '0;
            end else if (gnt_fire && (owner == REQ_DATA) && !instr_forced) begin
                starve_q <= starve_q + 1'b1;
            end

            // A flush during a pending instr phase cannot retract it; remember to drop it.
            if (gnt_fire) begin
                drop_pend_q <= 1'b0;
            end else if (req_ok && (owner == REQ_INSTR) && instr_flush_in) begin
                drop_pend_q <= 1'b1;
            end

            if (mem_rvalid_in && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req_out            = 1'b0;
        mem_addr_out           = '0;
        mem_we_out             = 1'b0;
        mem_be_out             = '0;
        mem_wdata_out          = '0;
        instr_gnt_out          = 1'b0;
        data_gnt_out           = 1'b0;
        instr_rvalid_out       = 1'b0;
        data_rvalid_out        = 1'b0;
        instr_rdata_out        = '0;
        data_rdata_out         = '0;
        err_unexpected_rsp_out = 1'b0;
        if (!reset) begin
            mem_req_out            = req_ok;
            mem_addr_out           = (owner == REQ_DATA) ? data_addr_in : instr_addr_in;
            mem_we_out             = (owner == REQ_DATA) && data_we_in;
            mem_be_out             = (owner == REQ_DATA) ? data_be_in : '1;
            mem_wdata_out          = (owner == REQ_DATA) ? data_wdata_in : '0;
            instr_gnt_out          = gnt_fire && (owner == REQ_INSTR);
            data_gnt_out           = gnt_fire && (owner == REQ_DATA);
            instr_rvalid_out       = pop && (head.id == REQ_INSTR) && !head.drop;
            data_rvalid_out        = pop && (head.id == REQ_DATA) && !head.drop;
            instr_rdata_out        = mem_rdata_in;
            data_rdata_out         = mem_rdata_in;
            err_unexpected_rsp_out = err_q;
        end
    end

`ifndef SYNTHESIS
    a_locked_req_held: assert property (
        @(posedge clk) disable iff (reset) (state_q == LOCKED) |-> owner_req
    );
`endif

endmodule
